// File: rtl/zigzag_pkg.sv
// Shared definitions for the zigzag (rail-fence) encryption and decryption
// blocks: start token, supported rail counts and the IDLE/EMIT state encoding.
package zigzag_pkg;

   // Character value that ends a message and starts processing.
   localparam logic [7:0] START_TOKEN = 8'hFA;

   // Rail counts with a real zigzag pattern; any other key is passthrough.
   localparam int KEY_RAILS2 = 2;
   localparam int KEY_RAILS3 = 3;

   typedef enum logic {
      IDLE = 1'b0,   // collecting characters
      EMIT = 1'b1    // streaming the processed message
   } state_t;

endpackage

// File: rtl/zigzag_index_gen.sv
// Read-order generator for rail-fence encryption.
// Walks the buffer row by row: each row has a start index and a fixed step,
// and a row is abandoned as soon as the next index would reach n.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   n          : number of buffered characters
//   key        : latched rail count (2, 3, other = single row)
//   start      : reset the walk to row 0, index 0
//   advance    : move to the next index in read order
//   ptr        : current buffer index (low address bits)
//   last       : ptr is the final index of the message
module zigzag_index_gen
   import zigzag_pkg::*;
#(
   parameter int KEY_WIDTH  = 16,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [KEY_WIDTH-1:0]  n,
   input  logic [KEY_WIDTH-1:0]  key,
   input  logic                  start,
   input  logic                  advance,
   output logic [ADDR_WIDTH-1:0] ptr,
   output logic                  last
);

   localparam logic [KEY_WIDTH-1:0] K2 = KEY_WIDTH'(KEY_RAILS2);
   localparam logic [KEY_WIDTH-1:0] K3 = KEY_WIDTH'(KEY_RAILS3);

   logic [KEY_WIDTH-1:0] ptr_reg, row_reg;
   logic [KEY_WIDTH-1:0] ptr_next, row_next;
   logic [KEY_WIDTH-1:0] step, nof_rows, ptr_step, row_inc;
   logic                 row_end, next_row_ok;

   always_comb begin
      nof_rows = KEY_WIDTH'(1);
      step     = KEY_WIDTH'(1);
      if (key == K2) begin
         nof_rows = K2;
         step     = KEY_WIDTH'(2);
      end else if (key == K3) begin
         nof_rows = K3;
         // Middle rail is visited twice per zigzag period of 4.
         step     = (row_reg == KEY_WIDTH'(1)) ? KEY_WIDTH'(2) : KEY_WIDTH'(4);
      end

      ptr_step = ptr_reg + step;
      row_inc  = row_reg + KEY_WIDTH'(1);
      row_end  = (ptr_step >= n);
      // Row r starts at index r, so a row exists only if r < n. Once one row
      // is empty every later row is empty too, so only the next one matters.
      next_row_ok = (row_inc < nof_rows) && (row_inc < n);
      last        = row_end && !next_row_ok;

      ptr_next = row_end ? row_inc : ptr_step;
      row_next = row_end ? row_inc : row_reg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         ptr_reg <= '0;
         row_reg <= '0;
      end else if (advance) begin
         ptr_reg <= ptr_next;
         row_reg <= row_next;
      end
   end

   assign ptr = ptr_reg[ADDR_WIDTH-1:0];

endmodule

// File: rtl/zigzag_encryption.sv
// Rail-fence (zigzag) encryptor.
// Collects plaintext characters until the start token, then streams the
// ciphertext one character per cycle and returns to collecting.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   data_i     : plaintext character or start token
//   valid_i    : data_i valid
//   key        : rail count, sampled when the token is accepted
//   busy       : high while emitting; inputs are ignored
//   data_o     : ciphertext character (0 when valid_o is low)
//   valid_o    : data_o valid
module zigzag_encryption
   import zigzag_pkg::*;
#(
   parameter int                 D_WIDTH                = 8,
   parameter int                 KEY_WIDTH              = 16,
   parameter int                 MAX_NOF_CHARS          = 50,
   parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = D_WIDTH'(START_TOKEN)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [D_WIDTH-1:0]   data_i,
   input  logic                 valid_i,
   input  logic [KEY_WIDTH-1:0] key,
   output logic                 busy,
   output logic [D_WIDTH-1:0]   data_o,
   output logic                 valid_o
);

   localparam int                   AW    = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
   localparam logic [KEY_WIDTH-1:0] MAX_N = KEY_WIDTH'(MAX_NOF_CHARS);

   state_t               state_reg, state_next;
   logic [KEY_WIDTH-1:0] n_reg, key_reg;
   logic [D_WIDTH-1:0]   buf_mem [MAX_NOF_CHARS];
   logic                 reading_reg, rd_valid_reg, busy_reg, valid_o_reg;
   logic [D_WIDTH-1:0]   rd_data_reg, data_o_reg;

   logic                 accept_char, accept_token, finish, advance;
   logic [AW-1:0]        ptr;
   logic                 last;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept_token) state_next = EMIT;
         EMIT:    if (finish)       state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- control strobes ----------------
   always_comb begin
      accept_char  = 1'b0;
      accept_token = 1'b0;
      advance      = 1'b0;
      finish       = 1'b0;
      if (state_reg == IDLE) begin
         // Characters beyond the buffer depth are dropped; n saturates.
         accept_char  = valid_i && (data_i != START_ENCRYPTION_TOKEN) && (n_reg < MAX_N);
         accept_token = valid_i && (data_i == START_ENCRYPTION_TOKEN);
      end else begin
         advance = reading_reg;
         // Done once the read/output pipeline has drained. busy_reg gates the
         // first EMIT cycle so busy always lasts n+1 cycles, even for n=0.
         finish  = busy_reg && !reading_reg && !rd_valid_reg;
      end
   end

   zigzag_index_gen #(
      .KEY_WIDTH  (KEY_WIDTH),
      .ADDR_WIDTH (AW)
   ) u_index_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .n       (n_reg),
      .key     (key_reg),
      .start   (accept_token),
      .advance (advance),
      .ptr     (ptr),
      .last    (last)
   );

   // ---------------- collect side ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         n_reg   <= '0;
         key_reg <= '0;
      end else begin
         if (accept_char)  n_reg   <= n_reg + KEY_WIDTH'(1);
         if (finish)       n_reg   <= '0;
         if (accept_token) key_reg <= key;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || finish) begin
         for (int i = 0; i < MAX_NOF_CHARS; i++) buf_mem[i] <= '0;
      end else if (accept_char) begin
         buf_mem[n_reg[AW-1:0]] <= data_i;
      end
   end

   // ---------------- emit side ----------------
   // Two-stage pipeline: buffer read, then output register. The first
   // character therefore appears two edges after the token.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reading_reg  <= 1'b0;
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
         busy_reg     <= 1'b0;
         valid_o_reg  <= 1'b0;
         data_o_reg   <= '0;
      end else begin
         if (accept_token)          reading_reg <= (n_reg != '0);
         else if (advance && last)  reading_reg <= 1'b0;

         rd_valid_reg <= advance;
         rd_data_reg  <= advance ? buf_mem[ptr] : '0;

         if (finish)                 busy_reg <= 1'b0;
         else if (state_reg == EMIT) busy_reg <= 1'b1;

         valid_o_reg <= rd_valid_reg;
         data_o_reg  <= rd_data_reg;
      end
   end

   assign busy    = busy_reg;
   assign valid_o = valid_o_reg;
   assign data_o  = data_o_reg;

endmodule

// File: tb/tb_zigzag_encryption.sv
module tb_zigzag_encryption;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  data_i;
   logic        valid_i;
   logic [15:0] key;
   logic        busy;
   logic [7:0]  data_o;
   logic        valid_o;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   zigzag_encryption dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (data_i),
      .valid_i (valid_i),
      .key     (key),
      .busy    (busy),
      .data_o  (data_o),
      .valid_o (valid_o)
   );

   // Scoreboard: every valid output character is compared with the oldest
   // expected character; idle cycles must show data_o = 0.
   always @(negedge clk) begin
      if (mon_en) begin
         if (valid_o) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_out: got %h, expected no output", data_o);
            end
            if (exp_q.size() != 0) begin
               logic [7:0] e;
               e = exp_q.pop_front();
               checks++;
               assert (data_o === e) else begin
                  errors++;
                  $error("FAIL char: got %h (%c), expected %h (%c)", data_o, data_o, e, e);
               end
               $display("out char %c expected %c", data_o, e);
            end
         end else begin
            checks++;
            assert (data_o === 8'h00) else begin
               errors++;
               $error("FAIL data_idle: got %h, expected 00", data_o);
            end
         end
      end
   end

   // Independent reference: rail of position i in a zigzag, then rail order.
   function automatic string rail_model(input string m, input int k);
      string r = "";
      int    nr = (k == 2) ? 2 : (k == 3) ? 3 : 1;
      for (int rail = 0; rail < nr; rail++) begin
         for (int i = 0; i < m.len(); i++) begin
            int ri;
            if (k == 2)      ri = i % 2;
            else if (k == 3) ri = (i % 4 == 0) ? 0 : (i % 4 == 2) ? 2 : 1;
            else             ri = 0;
            if (ri == rail) r = {r, m.substr(i, i)};
         end
      end
      return r;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic send_chars(input string msg, input int k);
      key = 16'(k);
      for (int i = 0; i < msg.len(); i++) begin
         @(negedge clk);
         valid_i = 1'b1;
         data_i  = msg[i];
      end
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = 8'hFA;
      @(negedge clk);            // just after the token edge T
      valid_i = 1'b0;
      data_i  = 8'h00;
   endtask

   // Sends msg + token, queues exp, then measures busy/valid timing.
   task automatic run_msg(input string tag, input string msg, input int k,
                          input string exp, input bit noise);
      int  busy_cnt = 0, vcnt = 0, first_v = -1, last_v = -1;
      bit  done = 1'b0;
      int  n = exp.len();
      for (int i = 0; i < n; i++) exp_q.push_back(exp[i]);
      send_chars(msg, k);
      check({tag, "_busy_at_T"}, int'(busy), 0);
      for (int c = 1; c <= n + 40 && !done; c++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (valid_o) begin
            vcnt++;
            if (first_v < 0) first_v = c;
            last_v = c;
         end
         if (busy_cnt > 0 && !busy) done = 1'b1;
         if (noise && busy) begin
            valid_i = 1'b1;
            data_i  = (c % 3 == 1) ? 8'hFA : 8'($urandom_range(65, 90));
         end else begin
            valid_i = 1'b0;
            data_i  = 8'h00;
         end
      end
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_busy_cycles"}, busy_cnt, n + 1);
      check({tag, "_valid_cycles"}, vcnt, n);
      check({tag, "_first_valid"}, first_v, (n > 0) ? 2 : -1);
      check({tag, "_last_valid"}, last_v, (n > 0) ? n + 1 : -1);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      exp_q.delete();
      $display("msg %s key %0d n %0d busy %0d valid %0d", tag, k, n, busy_cnt, vcnt);
   endtask

   initial begin
      string s52, s50, r;
      rst_n   = 1'b0;
      valid_i = 1'b0;
      data_i  = 8'h00;
      key     = 16'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(valid_o), 0);
      check("rst_data", int'(data_o), 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      run_msg("k3_hello", "HELLOWORLD", 3, "HOLELWRDLO", 1'b0);
      run_msg("k2_hello", "HELLOWORLD", 2, "HLOOLELWRD", 1'b0);
      run_msg("k2_abc",   "ABC",        2, "ACB",        1'b0);
      run_msg("k5_pass",  "ABCD",       5, "ABCD",       1'b0);
      run_msg("k3_one",   "A",          3, "A",          1'b0);
      run_msg("k3_two",   "AB",         3, "AB",         1'b0);
      run_msg("empty",    "",           3, "",           1'b0);

      // Reset in the middle of emission.
      for (int i = 0; i < 10; i++) exp_q.push_back(8'("HOLELWRDLO" >> (8 * (9 - i))));
      send_chars("HELLOWORLD", 3);
      repeat (5) @(negedge clk);  // 4 characters have been shown
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_queue_left", exp_q.size(), 6);
      check("midrst_valid", int'(valid_o), 0);
      check("midrst_data", int'(data_o), 0);
      check("midrst_busy", int'(busy), 0);
      exp_q.delete();
      rst_n = 1'b1;
      run_msg("k3_xyz_noise", "XYZ", 3, "XYZ", 1'b1);

      // Overflow: 52 characters, only the first 50 survive.
      s52 = "";
      for (int i = 0; i < 52; i++) s52 = {s52, string'(8'(65 + (i % 26)))};
      s50 = s52.substr(0, 49);
      run_msg("k1_overflow", s52, 1, s50, 1'b0);

      // Longer random messages against the reference model.
      r = "";
      for (int i = 0; i < 13; i++) r = {r, string'(8'($urandom_range(97, 122)))};
      run_msg("k3_rand13", r, 3, rail_model(r, 3), 1'b0);
      r = "";
      for (int i = 0; i < 7; i++) r = {r, string'(8'($urandom_range(97, 122)))};
      run_msg("k2_rand7", r, 2, rail_model(r, 2), 1'b0);
      run_msg("k3_full50", s50, 3, rail_model(s50, 3), 1'b0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/zigzag_encryption.md
Name: zigzag_encryption

Overview:
Buffers a plaintext message one character at a time, then emits it rail-fence (zigzag) encrypted, one character per cycle.
- Key 2 and key 3 are supported; any other key passes the message through unchanged.
- It is the transmit-side counterpart of the zigzag decryption block, with an identical interface and start-token convention.
- Its output stream, followed by the token, can be fed directly into the decryptor for loopback.

Parameters:
D_WIDTH, 8, character width in bits
KEY_WIDTH, 16, key width; also the width of the internal counters
MAX_NOF_CHARS, 50, buffer depth in characters
START_ENCRYPTION_TOKEN, 8'hFA, data_i value that ends the message and triggers encryption

Ports:
clk  in  1  system clock
rst_n  in  1  reset; rst_n is synchronous, active-low; clock clk
data_i  in  D_WIDTH  plaintext character, or the start token
valid_i  in  1  data_i is valid this cycle
key  in  KEY_WIDTH  number of rails (2, 3, other = passthrough)
busy  out  1  high while emitting ciphertext; input is ignored
data_o  out  D_WIDTH  ciphertext character
valid_o  out  1  data_o is valid

Behaviour:
- Reset (rst_n=0 at an edge): busy=0, valid_o=0, data_o=0, count n=0, all pointers/state cleared, buffer cleared. Reset overrides all other activity, including mid-emission; the partial message is discarded.
- State IDLE/COLLECT, busy=0:
  - valid_i=1 with data_i != token: store the character at buf[n], then n<=n+1.
  - If n==MAX_NOF_CHARS, the character is dropped and n saturates.
- Token accepted (valid_i=1, data_i==token, busy=0) at edge T:
  - Latch key internally; the key port is ignored afterwards.
  - busy=1 from T+1.
  - Initialise row=0 and ptr=0.
- State EMIT, busy=1:
  - One ciphertext character per cycle, valid_o=1, on the edges T+2 .. T+1+n. Output is contiguous with no gaps.
  - At edge T+2+n: valid_o=0, data_o=0, busy=0, n=0, buffer cleared, return to IDLE.
  - Total busy duration is n+1 cycles.
- Read-order generation (ptr indexes buf; each output consumes buf[ptr]):
  - Key 2: row0 starts at 0, step 2; row1 starts at 1, step 2.
  - Key 3: row0 starts at 0, step 4; row1 starts at 1, step 2; row2 starts at 2, step 4. Row 1 thereby covers indices 4m+1 and 4m+3.
  - Other keys: a single row starting at 0, step 1.
  - Row advance: if ptr+step >= n, go to the next row start. Skip a row whose start >= n; for example n=1 with key 3 emits only row 0.
  - Pointer arithmetic is done in KEY_WIDTH bits; no wrap is possible because n <= MAX_NOF_CHARS.
- n=0 when the token arrives: busy high for exactly 1 cycle, no valid_o pulse.
- valid_i during EMIT, including a second token: ignored, nothing stored.
- data_o=0 whenever valid_o=0.
- Token value as data: it can never be stored.

Decomposition:
- Shared package zigzag_pkg holds:
  - START_TOKEN
  - key constants KEY_RAILS2=2, KEY_RAILS3=3
  - state encoding IDLE/EMIT
  - This package is shared with the decryption block.
- One sub-module, zigzag_index_gen: given n, latched key, start and advance, it produces ptr and a last flag using the row/start/step logic above.
- The top level holds the buffer, the collect counter and the output registers.

Test Plan:
- Key 3, input "HELLOWORLD" (10 chars) then 8'hFA → 10 contiguous valid_o cycles giving "HOLELWRDLO". busy is high for 11 cycles and then drops.
- Key 2, same input → "HLOOLELWRD". Then a second message "ABC" with key 2 → "ACB", proving the buffer and counters were cleared.
- Key 5 (passthrough), "ABCD" → "ABCD". Key 3, "A" → "A". Key 3, "AB" → "AB".
- Token with an empty buffer → busy pulses 1 cycle, valid_o stays 0, data_o stays 0.
- Key 3, "HELLOWORLD": assert rst_n=0 after 4 output characters → outputs zero at the next edge. A fresh message "XYZ" with key 3 then yields "XYZ". Also drive valid_i and data_i during EMIT → the output is unaffected.
- Send 52 chars with key 1 → only the first 50 are emitted, in order. Loop the output through the decryption block with the same key → the original plaintext is recovered, for key 2 and key 3.
